// File: rtl/data_out_uart_tx_if.sv
// Bundles the data_out tap (data_in/en) with the UART transmitter's status outputs.
// The master drives the byte and enable; the slave drives tx and the FIFO status.
interface data_out_uart_tx_if #(
   parameter int FIFO_DEPTH = 4
);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   // No handshake: every change of data_in is accepted or dropped on the edge it is seen.
   logic [7:0]    data_in;
   logic          en;
   logic          tx;
   logic          busy;
   logic          overflow;
   logic [LW-1:0] level;

   modport master (output data_in, en, input tx, busy, overflow, level);
   modport slave  (input data_in, en, output tx, busy, overflow, level);
endinterface

// File: rtl/data_out_uart_tx.sv
// Captures every change of the CPU data_out byte into a small FIFO and sends each byte
// as UART 8N1, LSB first. The CPU is never stalled; bytes arriving at a full FIFO are dropped.
module data_out_uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                clk,
   input  logic                rst,
   data_out_uart_tx_if.slave   bus,
   output logic [1:0]          dbg_state_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int LW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    prev_q;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [LW-1:0] level_q;
   logic          overflow_q;

   state_t        state_q;
   logic [BW-1:0] baud_q;
   logic [2:0]    bit_q;
   logic [7:0]    shreg_q;
   logic          tx_q;

   logic push, pop, full, push_ok, baud_last;

   always_comb begin
      push      = bus.en && (bus.data_in != prev_q);
      pop       = (state_q == IDLE) && (level_q != '0);
      full      = (level_q == LW'(FIFO_DEPTH));
      // A pop in the same cycle frees the slot the new byte lands in.
      push_ok   = push && (!full || pop);
      baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_q     <= 8'h00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      end else begin
         prev_q <= bus.data_in;
         if (push_ok) begin
            mem_q[wr_ptr_q] <= bus.data_in;
            wr_ptr_q        <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !push_ok) overflow_q <= 1'b1;
         unique case ({push_ok, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // tx_q is loaded with the value of the phase being entered, so the line is glitch-free.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= 8'h00;
         tx_q    <= 1'b1;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  shreg_q <= mem_q[rd_ptr_q];
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  state_q <= START;
               end
            end
            START: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shreg_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     tx_q    <= 1'b1;
                     state_q <= STOP;
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shreg_q <= {1'b0, shreg_q[7:1]};
                     tx_q    <= shreg_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud_q  <= '0;
                  state_q <= IDLE;
               end else begin
                  baud_q <= baud_q + BW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.tx       = tx_q;
   assign bus.busy     = (state_q != IDLE) || (level_q != '0);
   assign bus.overflow = overflow_q;
   assign bus.level    = level_q;
   assign dbg_state_o  = state_q;
endmodule
